// File: rtl/arith_unit_if.sv
// Issue encoding shared by the RS and the arith unit,
// plus the RS-issue / CDB-broadcast bundle.
package arith_pkg;
  localparam logic [5:0] OP_NOP    = 6'd0;
  localparam logic [5:0] OP_ADD    = 6'd1;
  localparam logic [5:0] OP_SUB    = 6'd2;
  localparam logic [5:0] OP_AND    = 6'd3;
  localparam logic [5:0] OP_OR     = 6'd4;
  localparam logic [5:0] OP_XOR    = 6'd5;
  localparam logic [5:0] OP_SLL    = 6'd6;
  localparam logic [5:0] OP_SRL    = 6'd7;
  localparam logic [5:0] OP_SRA    = 6'd8;
  localparam logic [5:0] OP_SLT    = 6'd9;
  localparam logic [5:0] OP_SLTU   = 6'd10;
  localparam logic [5:0] OP_ADDI   = 6'd11;
  localparam logic [5:0] OP_ANDI   = 6'd12;
  localparam logic [5:0] OP_ORI    = 6'd13;
  localparam logic [5:0] OP_XORI   = 6'd14;
  localparam logic [5:0] OP_SLLI   = 6'd15;
  localparam logic [5:0] OP_SRLI   = 6'd16;
  localparam logic [5:0] OP_SRAI   = 6'd17;
  localparam logic [5:0] OP_SLTI   = 6'd18;
  localparam logic [5:0] OP_SLTIU  = 6'd19;
  localparam logic [5:0] OP_LUI    = 6'd20;
  localparam logic [5:0] OP_AUIPC  = 6'd21;
  localparam logic [5:0] OP_JAL    = 6'd22;
  localparam logic [5:0] OP_JALR   = 6'd23;
  localparam logic [5:0] OP_BEQ    = 6'd24;
  localparam logic [5:0] OP_BNE    = 6'd25;
  localparam logic [5:0] OP_BLT    = 6'd26;
  localparam logic [5:0] OP_BGE    = 6'd27;
  localparam logic [5:0] OP_BLTU   = 6'd28;
  localparam logic [5:0] OP_BGEU   = 6'd29;
  localparam logic [5:0] OP_MUL    = 6'd30;
  localparam logic [5:0] OP_MULH   = 6'd31;
  localparam logic [5:0] OP_MULHSU = 6'd32;
  localparam logic [5:0] OP_MULHU  = 6'd33;
endpackage

interface arith_unit_if;
  logic [5:0]  openum_from_rs;
  logic [31:0] V1_from_rs;
  logic [31:0] V2_from_rs;
  logic [31:0] pc_from_rs;
  logic [31:0] imm_from_rs;
  logic [3:0]  rob_id_from_rs;
  logic        busy_to_rs;
  logic        cdb_valid;
  logic [3:0]  cdb_rob_id;
  logic [31:0] cdb_result;
  logic        cdb_jump;
  logic [31:0] cdb_target_pc;

  modport master (
    output openum_from_rs, V1_from_rs, V2_from_rs,
    output pc_from_rs, imm_from_rs, rob_id_from_rs,
    input  busy_to_rs, cdb_valid, cdb_rob_id,
    input  cdb_result, cdb_jump, cdb_target_pc
  );

  modport slave (
    input  openum_from_rs, V1_from_rs, V2_from_rs,
    input  pc_from_rs, imm_from_rs, rob_id_from_rs,
    output busy_to_rs, cdb_valid, cdb_rob_id,
    output cdb_result, cdb_jump, cdb_target_pc
  );
endinterface

// File: rtl/arith_unit.sv
// Arith unit: RV32I ALU/branch ops with registered CDB broadcast.
// Define ARITH_MUL_EN to build the 4-cycle RV32M multiplier path.
module arith_unit
  import arith_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        misbranch_flag,
  arith_unit_if.slave bus
);
  logic [5:0]  op;
  logic [31:0] a, b, pc, imm;
  logic [31:0] pc4, pc_imm;
  logic [3:0]  rob;

  assign op     = bus.openum_from_rs;
  assign a      = bus.V1_from_rs;
  assign b      = bus.V2_from_rs;
  assign pc     = bus.pc_from_rs;
  assign imm    = bus.imm_from_rs;
  assign rob    = bus.rob_id_from_rs;
  assign pc4    = pc + 32'd4;
  assign pc_imm = pc + imm;

  logic [31:0] res, tgt;
  logic        jmp, br, is_br;

  always_comb begin
    res   = '0;
    jmp   = 1'b0;
    tgt   = '0;
    br    = 1'b0;
    is_br = 1'b0;
    unique case (op)
      OP_ADD:   res = a + b;
      OP_SUB:   res = a - b;
      OP_AND:   res = a & b;
      OP_OR:    res = a | b;
      OP_XOR:   res = a ^ b;
      OP_SLL:   res = a << b[4:0];
      OP_SRL:   res = a >> b[4:0];
      OP_SRA:   res = $signed(a) >>> b[4:0];
      OP_SLT:   res = {31'd0, $signed(a) < $signed(b)};
      OP_SLTU:  res = {31'd0, a < b};
      OP_ADDI:  res = a + imm;
      OP_ANDI:  res = a & imm;
      OP_ORI:   res = a | imm;
      OP_XORI:  res = a ^ imm;
      OP_SLLI:  res = a << imm[4:0];
      OP_SRLI:  res = a >> imm[4:0];
      OP_SRAI:  res = $signed(a) >>> imm[4:0];
      OP_SLTI:  res = {31'd0, $signed(a) < $signed(imm)};
      OP_SLTIU: res = {31'd0, a < imm};
      OP_LUI:   res = imm;
      OP_AUIPC: res = pc_imm;
      OP_JAL: begin
        res = pc4;
        jmp = 1'b1;
        tgt = pc_imm;
      end
      OP_JALR: begin
        res = pc4;
        jmp = 1'b1;
        tgt = (a + imm) & 32'hFFFF_FFFE;
      end
      OP_BEQ:  begin is_br = 1'b1; br = a == b; end
      OP_BNE:  begin is_br = 1'b1; br = a != b; end
      OP_BLT:  begin is_br = 1'b1; br = $signed(a) < $signed(b); end
      OP_BGE:  begin is_br = 1'b1; br = $signed(a) >= $signed(b); end
      OP_BLTU: begin is_br = 1'b1; br = a < b; end
      OP_BGEU: begin is_br = 1'b1; br = a >= b; end
      default: ;
    endcase
    if (is_br) begin
      jmp = br;
      tgt = br ? pc_imm : pc4;
    end
  end

  logic        busy, take, single, mul_done;
  logic [31:0] mul_res;
  logic [3:0]  mul_rob;

  assign take = rdy && !misbranch_flag && !busy
             && op != OP_NOP && rob != 4'd0;
  assign bus.busy_to_rs = busy;

`ifdef ARITH_MUL_EN
  typedef enum logic {IDLE, MUL_BUSY} state_e;
  state_e      state, state_nx;
  logic [1:0]  cnt, cnt_nx;
  logic        is_mul, start;
  logic        ma_sgn, mb_sgn, m_hi;
  logic [31:0] ma, mb;
  logic [3:0]  m_rob;
  logic [63:0] prod;

  assign is_mul   = op >= OP_MUL && op <= OP_MULHU;
  assign start    = take && is_mul;
  assign single   = take && !is_mul;
  assign busy     = state == MUL_BUSY;
  // product is written at cnt==1 so it is on the CDB while cnt==0
  assign mul_done = rdy && !misbranch_flag && busy && cnt == 2'd1;
  assign prod     = {{32{ma_sgn & ma[31]}}, ma}
                  * {{32{mb_sgn & mb[31]}}, mb};
  assign mul_res  = m_hi ? prod[63:32] : prod[31:0];
  assign mul_rob  = m_rob;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    if (rdy && misbranch_flag) begin
      state_nx = IDLE;
      cnt_nx   = '0;
    end else if (rdy) begin
      unique case (state)
        IDLE: if (start) begin
          state_nx = MUL_BUSY;
          cnt_nx   = 2'd3;
        end
        MUL_BUSY: begin
          if (cnt == 2'd0) state_nx = IDLE;
          else cnt_nx = cnt - 2'd1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ma     <= '0;
      mb     <= '0;
      m_rob  <= '0;
      ma_sgn <= 1'b0;
      mb_sgn <= 1'b0;
      m_hi   <= 1'b0;
    end else if (start) begin
      ma     <= a;
      mb     <= b;
      m_rob  <= rob;
      ma_sgn <= op == OP_MULH || op == OP_MULHSU;
      mb_sgn <= op == OP_MULH;
      m_hi   <= op != OP_MUL;
    end
  end
`else
  assign busy     = 1'b0;
  assign single   = take;
  assign mul_done = 1'b0;
  assign mul_res  = '0;
  assign mul_rob  = '0;
`endif

  // flush and rob-0 issues fall through to the valid-clear branch
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.cdb_valid     <= 1'b0;
      bus.cdb_rob_id    <= '0;
      bus.cdb_result    <= '0;
      bus.cdb_jump      <= 1'b0;
      bus.cdb_target_pc <= '0;
    end else if (rdy) begin
      if (mul_done) begin
        bus.cdb_valid     <= 1'b1;
        bus.cdb_rob_id    <= mul_rob;
        bus.cdb_result    <= mul_res;
        bus.cdb_jump      <= 1'b0;
        bus.cdb_target_pc <= '0;
      end else if (single) begin
        bus.cdb_valid     <= 1'b1;
        bus.cdb_rob_id    <= rob;
        bus.cdb_result    <= res;
        bus.cdb_jump      <= jmp;
        bus.cdb_target_pc <= tgt;
      end else begin
        bus.cdb_valid     <= 1'b0;
      end
    end
  end
endmodule

// File: doc/arith_unit.md
ARITH_UNIT -- requirements
Module: arith_unit

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1, reset, asynchronous and active-low.
REQ-003 SHALL have port rdy, input, 1, global ready; low = hold all state and outputs.
REQ-004 SHALL have port misbranch_flag, input, 1, pipeline flush.
REQ-005 SHALL have inputs openum_from_rs (6), V1_from_rs (32), V2_from_rs (32), pc_from_rs (32), imm_from_rs (32), rob_id_from_rs (4): one issued op per cycle; OPENUM_NOP = no issue.
REQ-006 SHALL have output busy_to_rs, 1, high = multi-cycle op in flight, RS must issue NOP.
REQ-007 SHALL have outputs cdb_valid (1), cdb_rob_id (4), cdb_result (32): Arith CDB broadcast.
REQ-008 SHALL have outputs cdb_jump (1), cdb_target_pc (32): branch/jump outcome, meaningful only with cdb_valid.

Function
REQ-009 SHALL register results: a single-cycle op accepted in cycle N appears on CDB in cycle N+1 for exactly one cycle.
REQ-010 SHALL treat rob_id 0 as "no entry"; an issue with rob_id 0 SHALL be ignored.
REQ-011 SHALL compute RV32I ALU ops (ADD, SUB, AND, OR, XOR, SLL, SRL, SRA, SLT, SLTU and immediate forms using imm); shift amount = low 5 bits of operand 2.
REQ-012 SHALL compute LUI result = imm; AUIPC result = pc + imm; all sums modulo 2^32.
REQ-013 SHALL for JAL: result = pc + 4, jump = 1, target = pc + imm; JALR: result = pc + 4, jump = 1, target = (V1 + imm) with bit 0 cleared.
REQ-014 SHALL for BEQ/BNE/BLT/BGE/BLTU/BGEU: result = 0, jump = condition (signed/unsigned per op), target = pc + imm if taken else pc + 4.
REQ-015 SHALL drive cdb_jump = 0 and cdb_target_pc = 0 for non-control ops.
REQ-016 SHALL use two states: IDLE (accept issue) and MUL_BUSY (iterating multiplier).
REQ-017 SHALL in IDLE, on a MUL-class op, latch operands and rob_id, go MUL_BUSY, assert busy_to_rs combinationally from state.
REQ-018 SHALL in MUL_BUSY decrement a 2-bit counter from 3; at counter 0 broadcast the product (cdb_valid 1 for one cycle) and return to IDLE; total latency 4 cycles issue-to-CDB.
REQ-019 SHALL ignore any non-NOP issue arriving while MUL_BUSY (RS contract violation; no state change).
REQ-020 SHALL on misbranch_flag: drop any pending result, cdb_valid = 0 next cycle, abort MUL_BUSY to IDLE, ignore same-cycle issue.
REQ-021 SHALL with rdy low freeze state, counter, and all outputs (cdb_valid held, not re-pulsed afterwards beyond one effective cycle).

Reset
REQ-022 SHALL on rst low asynchronously set state IDLE, counter 0, busy_to_rs 0, cdb_valid 0, cdb_rob_id 0, cdb_result 0, cdb_jump 0, cdb_target_pc 0.
REQ-023 SHALL on reset mid-multiply discard the operation with no CDB broadcast.

Configuration
REQ-024 SHALL compile the multiplier only when macro ARITH_MUL_EN is defined: MUL, MULH, MULHSU, MULHU per RV32M (low/high 32 bits, signedness per op).
REQ-025 SHALL without ARITH_MUL_EN omit MUL_BUSY state and counter, tie busy_to_rs to 0, and treat MUL-class openums as single-cycle ops returning result 0.

Verification
REQ-026 SHALL cover ADD V1=5 V2=7 rob 3 in cycle N -> cycle N+1 cdb_valid 1, rob 3, result 12, jump 0.
REQ-027 SHALL cover BLT V1=0xFFFFFFFF V2=1 pc=0x100 imm=0x20 -> jump 1, target 0x120, result 0; BLTU same operands -> jump 0, target 0x104.
REQ-028 SHALL cover JALR V1=0x1003 imm=4 pc=0x200 -> result 0x204, jump 1, target 0x1006.
REQ-029 SHALL cover (ARITH_MUL_EN) MULH V1=0x80000000 V2=2 rob 5 -> busy_to_rs high 4 cycles, cdb result 0xFFFFFFFF rob 5 at cycle N+4, ADD issued during busy ignored.
REQ-030 SHALL cover misbranch_flag in cycle N+2 of a multiply -> no CDB broadcast, busy_to_rs 0 in N+3, subsequent ADD completes normally.
REQ-031 SHALL cover rst low mid-operation and rdy low for 3 cycles with pending result -> outputs zeroed / outputs frozen, single result delivered after rdy returns.
